// File: rtl/multi_debounce.sv
`default_nettype none
// ============================================================================
// Module      : multi_debounce
// Description : NCH-channel pin debouncer with a 2-flop synchroniser, exact
//               stable-count latency, press/release strobes and an optional
//               long-press strobe (enabled by DEBOUNCE_LONGPRESS_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module multi_debounce #(
    parameter int unsigned NCH        = 4,
    parameter int unsigned DELAY      = 20'hf4240,
    parameter int unsigned CNT_W      = 20,
    parameter bit          ACTIVE_LOW = 1'b1,
    parameter int unsigned HOLD_CYC   = 24'd3000000,
    parameter int unsigned HOLD_W     = 24
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] signal,
    output logic [NCH-1:0] level,
    output logic [NCH-1:0] pressed,
    output logic [NCH-1:0] press_pulse,
    output logic [NCH-1:0] release_pulse,
    output logic [NCH-1:0] hold_pulse
);

    localparam logic             c_IDLE     = ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DELAY - 1);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic             r_sync1;
        logic             r_sync2;
        logic             r_stable;
        logic             r_pressed;
        logic             r_press;
        logic             r_release;
        logic [CNT_W-1:0] r_cnt;
        logic             w_diff;
        logic             w_commit;

        assign w_diff   = (r_sync2 != r_stable);
        assign w_commit = w_diff && (r_cnt == c_CNT_LAST);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync1   <= c_IDLE;
                r_sync2   <= c_IDLE;
                r_stable  <= c_IDLE;
                r_pressed <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_cnt     <= '0;
            end else begin
                r_sync1   <= signal[i];
                r_sync2   <= r_sync1;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                if (!w_diff) begin
                    r_cnt <= '0;
                end else if (w_commit) begin
                    r_stable  <= r_sync2;
                    r_pressed <= (r_sync2 != c_IDLE);
                    r_press   <= (r_sync2 != c_IDLE);
                    r_release <= (r_sync2 == c_IDLE);
                    r_cnt     <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign level[i]         = r_stable;
        assign pressed[i]       = r_pressed;
        assign press_pulse[i]   = r_press;
        assign release_pulse[i] = r_release;

`ifdef DEBOUNCE_LONGPRESS_EN
        localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
        localparam logic [HOLD_W-1:0] c_HOLD_SAT  = HOLD_W'(HOLD_CYC);

        logic [HOLD_W-1:0] r_hold;
        logic              r_hold_pulse;

        // A commit while pressed is always a release, so it clears the hold count.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_hold       <= '0;
                r_hold_pulse <= 1'b0;
            end else begin
                r_hold_pulse <= 1'b0;
                if (w_commit) begin
                    r_hold <= '0;
                end else if (r_pressed && (r_hold != c_HOLD_SAT)) begin
                    r_hold <= r_hold + 1'b1;
                    if (r_hold == c_HOLD_LAST) begin
                        r_hold_pulse <= 1'b1;
                    end
                end
            end
        end

        assign hold_pulse[i] = r_hold_pulse;
`else
        assign hold_pulse[i] = 1'b0;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_debounce
// Description : Directed self-checking bench for multi_debounce (NCH=4, DELAY=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] signal;
    logic [3:0] level;
    logic [3:0] pressed;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
    logic [3:0] hold_pulse;

    int total = 0;
    int bad   = 0;

    int n_press   [4] = '{default: 0};
    int n_release [4] = '{default: 0};
    int n_hold    [4] = '{default: 0};
    int n_overlap     = 0;

    int snap_a;
    int snap_b;

    multi_debounce #(
        .NCH        (4),
        .DELAY      (4),
        .CNT_W      (8),
        .ACTIVE_LOW (1'b1),
        .HOLD_CYC   (10),
        .HOLD_W     (8)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .signal        (signal),
        .level         (level),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .hold_pulse    (hold_pulse)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (press_pulse[i] === 1'b1)   n_press[i]++;
            if (release_pulse[i] === 1'b1) n_release[i]++;
            if (hold_pulse[i] === 1'b1)    n_hold[i]++;
        end
        if ((press_pulse & release_pulse) != 4'b0000) n_overlap++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst    = 1'b1;
        signal = 4'hF;
        repeat (3) step();
        chk("rst_level",   32'(level),         32'hF);
        chk("rst_pressed", 32'(pressed),       32'h0);
        chk("rst_press",   32'(press_pulse),   32'h0);
        chk("rst_release", 32'(release_pulse), 32'h0);
        chk("rst_hold",    32'(hold_pulse),    32'h0);
        rst = 1'b0;
        step();

        // Clean press on channel 0: level moves on edge 5 after capture
        signal = 4'hE;
        repeat (5) step();
        chk("press_early_level", 32'(level), 32'hF);
        step();
        chk("press_level",   32'(level),         32'hE);
        chk("press_pulse",   32'(press_pulse),   32'h1);
        chk("press_pressed", 32'(pressed),       32'h1);
        chk("press_release", 32'(release_pulse), 32'h0);
        step();
        chk("press_one_cycle", 32'(press_pulse), 32'h0);

        // Bounce on channel 1: low 3, high 1, then low and held
        signal = 4'hC;
        repeat (3) step();
        signal = 4'hE;
        step();
        signal = 4'hC;
        repeat (5) step();
        chk("bounce_no_event_level", 32'(level), 32'hE);
        chk("bounce_no_event_cnt",   32'(n_press[1]), 32'd0);
        step();
        chk("bounce_press_pulse", 32'(press_pulse), 32'h2);
        chk("bounce_level",       32'(level),       32'hC);
        step();
        chk("bounce_single_press", 32'(n_press[1]), 32'd1);

        // Release channel 0
        signal = 4'hD;
        repeat (5) step();
        chk("release_early_level", 32'(level), 32'hC);
        step();
        chk("release_level", 32'(level),         32'hD);
        chk("release_pulse", 32'(release_pulse), 32'h1);
        chk("release_no_press", 32'(press_pulse), 32'h0);
        step();
        chk("release_count0", 32'(n_release[0]), 32'd1);
        chk("press_count0",   32'(n_press[0]),   32'd1);

        // Back to all idle, then press all four together
        signal = 4'hF;
        repeat (7) step();
        chk("idle_level",     32'(level),        32'hF);
        chk("release_count1", 32'(n_release[1]), 32'd1);
        signal = 4'h0;
        repeat (5) step();
        chk("simul_early", 32'(press_pulse), 32'h0);
        step();
        chk("simul_press",   32'(press_pulse), 32'hF);
        chk("simul_pressed", 32'(pressed),     32'hF);

        // Reset while pressed: no release strobe, then re-press after latency
        snap_a = n_release[0] + n_release[1] + n_release[2] + n_release[3];
        rst = 1'b1;
        step();
        chk("rstp_level",   32'(level),         32'hF);
        chk("rstp_pressed", 32'(pressed),       32'h0);
        chk("rstp_press",   32'(press_pulse),   32'h0);
        chk("rstp_release", 32'(release_pulse), 32'h0);
        step();
        rst = 1'b0;
        repeat (5) step();
        chk("rstp_early_level", 32'(level), 32'hF);
        chk("rstp_no_release",
            32'(n_release[0] + n_release[1] + n_release[2] + n_release[3]), 32'(snap_a));
        step();
        chk("repress_pulse", 32'(press_pulse), 32'hF);
        chk("repress_level", 32'(level),       32'h0);

        // Reset with channel 0 counter at 2: partial count discarded
        signal = 4'hF;
        repeat (7) step();
        chk("mid_idle_level", 32'(level), 32'hF);
        snap_a = n_press[0] + n_press[1] + n_press[2] + n_press[3];
        signal = 4'hE;
        repeat (4) step();
        rst    = 1'b1;
        signal = 4'hF;
        step();
        chk("mid_rst_level", 32'(level), 32'hF);
        rst = 1'b0;
        repeat (8) step();
        chk("mid_no_press",
            32'(n_press[0] + n_press[1] + n_press[2] + n_press[3]), 32'(snap_a));
        chk("mid_level", 32'(level), 32'hF);

        // Long press on channel 0
        snap_b = n_hold[0];
        signal = 4'hE;
        repeat (6) step();
        chk("long_press_pulse", 32'(press_pulse), 32'h1);
        repeat (9) step();
        chk("hold_early", 32'(hold_pulse), 32'h0);
        step();
`ifdef DEBOUNCE_LONGPRESS_EN
        chk("hold_pulse", 32'(hold_pulse), 32'h1);
`else
        chk("hold_pulse_absent", 32'(hold_pulse), 32'h0);
`endif
        repeat (20) step();
`ifdef DEBOUNCE_LONGPRESS_EN
        chk("hold_single", 32'(n_hold[0] - snap_b), 32'd1);
`else
        chk("hold_none", 32'(n_hold[0] - snap_b), 32'd0);
`endif
        signal = 4'hF;
        repeat (6) step();
        chk("long_release_level", 32'(level),         32'hF);
        chk("long_release_pulse", 32'(release_pulse), 32'h1);

        chk("no_press_release_overlap", 32'(n_overlap), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
